// File: rtl/segment_port_arbiter.sv
// Arbitrates the segment register file's single read/write port pair between the
// microcode path (A) and the far-transfer sequencer (B), with round-robin and lock.
module segment_port_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [1:0]  a_sel,
    input  logic [15:0] a_wdata,
    input  logic        a_lock,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [1:0]  b_sel,
    input  logic [15:0] b_wdata,
    input  logic        b_lock,
    output logic        a_ack,
    output logic        b_ack,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [15:0] a_rdata,
    output logic [15:0] b_rdata,
    output logic [1:0]  sr_rd_sel,
    input  logic [15:0] sr_rd_val,
    output logic        sr_wr_en,
    output logic [1:0]  sr_wr_sel,
    output logic [15:0] sr_wr_val,
    output logic        owner_locked
);

    logic r_ready;
    logic r_last;          // 0 = A, 1 = B
    logic r_locked;
    logic r_lock_owner;    // 0 = A, 1 = B
    logic r_a_rvalid;
    logic r_b_rvalid;

    logic        w_gnt_a;
    logic        w_gnt_b;
    logic        w_gnt_any;
    logic        w_g_wr;
    logic        w_g_lock;
    logic [1:0]  w_g_sel;
    logic [15:0] w_g_wdata;
    logic        w_owner_lock;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (r_ready) begin
            if (r_locked) begin
                w_gnt_a = ~r_lock_owner & a_req;
                w_gnt_b = r_lock_owner & b_req;
            end else if (a_req && b_req) begin
                w_gnt_a = r_last;
                w_gnt_b = ~r_last;
            end else begin
                w_gnt_a = a_req;
                w_gnt_b = b_req;
            end
        end
    end

    assign w_gnt_any    = w_gnt_a | w_gnt_b;
    assign w_g_wr       = w_gnt_b ? b_wr    : a_wr;
    assign w_g_lock     = w_gnt_b ? b_lock  : a_lock;
    assign w_g_sel      = w_gnt_b ? b_sel   : a_sel;
    assign w_g_wdata    = w_gnt_b ? b_wdata : a_wdata;
    assign w_owner_lock = r_lock_owner ? b_lock : a_lock;

    assign a_ack     = w_gnt_a;
    assign b_ack     = w_gnt_b;
    assign sr_rd_sel = w_gnt_any ? w_g_sel : 2'd0;
    assign sr_wr_en  = w_gnt_any & w_g_wr;
    assign sr_wr_sel = sr_wr_en ? w_g_sel : 2'd0;
    assign sr_wr_val = sr_wr_en ? w_g_wdata : 16'd0;

    assign a_rvalid     = r_a_rvalid;
    assign b_rvalid     = r_b_rvalid;
    assign a_rdata      = r_a_rvalid ? sr_rd_val : 16'd0;
    assign b_rdata      = r_b_rvalid ? sr_rd_val : 16'd0;
    assign owner_locked = r_locked;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready      <= 1'b0;
            r_last       <= 1'b1;
            r_locked     <= 1'b0;
            r_lock_owner <= 1'b0;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_gnt_any) begin
                r_last       <= w_gnt_b;
                r_locked     <= w_g_lock;
                r_lock_owner <= w_gnt_b;
                r_a_rvalid   <= w_gnt_a & ~w_g_wr;
                r_b_rvalid   <= w_gnt_b & ~w_g_wr;
            end else begin
                r_a_rvalid <= 1'b0;
                r_b_rvalid <= 1'b0;
                // an idle holder that drops its lock gives up ownership
                if (r_locked && !w_owner_lock)
                    r_locked <= 1'b0;
            end
        end
    end

endmodule
